// File: rtl/boot_memory_if.sv
// boot_memory_if: loader byte stream and CPU memory port of the boot memory
interface boot_memory_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic                  cpu_reset;
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] memoryIn;
  logic [DATA_WIDTH-1:0] memoryOut;
  modport slave (
    input  load_start, load_valid, load_data, load_last, address, read, write, memoryIn,
    output load_ready, load_done, cpu_reset, memoryOut
  );
  modport master (
    output load_start, load_valid, load_data, load_last, address, read, write, memoryIn,
    input  load_ready, load_done, cpu_reset, memoryOut
  );
endinterface

// File: rtl/boot_memory.sv
// boot_memory: unified program/data memory that clears itself, loads a program over
// a valid/ready byte stream, then releases the CPU and serves its read/write port.
module boot_memory #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  boot_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, RUN} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_next, w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_we, w_xfer, r_load_ready, r_load_done, r_cpu_reset;
  logic                  w_unused_read;
  assign w_unused_read = bus.read;
  assign w_xfer = bus.load_valid & r_load_ready;
  always_comb begin
    w_next     = r_state;
    w_ptr_next = r_ptr;
    w_we       = 1'b0;
    w_waddr    = r_ptr;
    w_wdata    = '0;
    case (r_state)
      CLEAR: begin
        w_we       = 1'b1;
        w_ptr_next = r_ptr + 1'b1;
        w_next     = (r_ptr == LAST) ? IDLE : CLEAR;
      end
      IDLE: begin
        w_next     = bus.load_start ? LOAD : IDLE;
        w_ptr_next = bus.load_start ? '0 : r_ptr;
      end
      LOAD: if (w_xfer) begin
        w_we       = 1'b1;
        w_wdata    = bus.load_data;
        w_ptr_next = r_ptr + 1'b1;
        w_next     = (bus.load_last || r_ptr == LAST) ? RUN : LOAD;
      end
      RUN: begin
        // a CPU write coinciding with a reload request still commits
        w_we       = bus.write;
        w_waddr    = bus.address;
        w_wdata    = bus.memoryIn;
        w_next     = bus.load_start ? LOAD : RUN;
        w_ptr_next = bus.load_start ? '0 : r_ptr;
      end
      default: w_next = CLEAR;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_ptr        <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_cpu_reset  <= 1'b1;
    end else begin
      r_state      <= w_next;
      r_ptr        <= w_ptr_next;
      r_load_ready <= (w_next == LOAD);
      r_load_done  <= (w_next == RUN);
      r_cpu_reset  <= (w_next != RUN);
    end
  end
  // the array has no reset; the CLEAR state zeroes it word by word
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
  assign bus.load_ready = r_load_ready;
  assign bus.load_done  = r_load_done;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.memoryOut  = r_mem[bus.address];
endmodule
